// File: rtl/msg_pkg.sv
// Shared definitions for the message-assembly path: arbiter state encoding
// and parameter helpers. The message controller imports the same names.
package msg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } arbStateType;

   // Number of beats that make up one full message.
   function automatic int MAX_BEATS(input int msg_bytes, input int data_bytes);
      return msg_bytes / data_bytes;
   endfunction

   // Width of a source index; never narrower than one bit.
   function automatic int TID_W(input int num_src);
      return (num_src > 1) ? $clog2(num_src) : 1;
   endfunction

endpackage

// File: rtl/msg_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping at NUM_SRC.
module msg_rr_pick
   import msg_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int TW      = TID_W(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [TW-1:0]      ptr,
   output logic               found,
   output logic [TW-1:0]      idx
);

   int cand;

   // Walk the request vector starting at ptr; the first hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = (int'(ptr) + i) % NUM_SRC;
         if (!found && req[TW'(cand)]) begin
            found = 1'b1;
            idx   = TW'(cand);
         end
      end
   end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Packet-level round-robin arbiter in front of the message controller.
// One source holds the grant until its tlast; packets longer than a message
// are cut with tlast+tuser and the rest of the packet is drained.
//
// Handshake: a beat moves on any interface only in a cycle where tvalid and
// tready are both high at the rising edge; tvalid never waits for tready, and
// a presented output beat holds its payload until taken.
module msg_stream_arbiter
   import msg_pkg::*;
#(
   parameter int NUM_SRC       = 4,
   parameter int DATA_BYTES    = 8,
   parameter int TKEEP_WIDTH   = 8,
   parameter int MAX_MSG_BYTES = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC-1:0]              s_tvalid,
   output logic [NUM_SRC-1:0]              s_tready,
   input  logic [NUM_SRC-1:0]              s_tlast,
   input  logic [NUM_SRC-1:0]              s_tuser,
   input  logic [NUM_SRC*TKEEP_WIDTH-1:0]  s_tkeep,
   input  logic [NUM_SRC*8*DATA_BYTES-1:0] s_tdata,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic                            m_tlast,
   output logic                            m_tuser,
   output logic [TKEEP_WIDTH-1:0]          m_tkeep,
   output logic [8*DATA_BYTES-1:0]         m_tdata,
   output logic [$clog2(NUM_SRC)-1:0]      m_tid,
   output logic                            pkt_overflow,
   output logic [1:0]                      state_dbg
);

   localparam int TW = TID_W(NUM_SRC);
   localparam int DW = 8 * DATA_BYTES;
   localparam int KW = TKEEP_WIDTH;
   localparam int MB = MAX_BEATS(MAX_MSG_BYTES, DATA_BYTES);
   localparam int CW = (MB > 1) ? $clog2(MB) : 1;

   arbStateType   state, state_nxt;
   logic [TW-1:0] grant, grant_nxt;
   logic [TW-1:0] rr_ptr, rr_nxt;
   logic [CW-1:0] beat_cnt, cnt_nxt;
   logic [TW-1:0] next_ptr;
   logic          pick_found;
   logic [TW-1:0] pick_idx;
   logic          acc;
   logic          load;
   logic          force_end;
   logic [DW-1:0] sel_data;
   logic [KW-1:0] sel_keep;
   logic          sel_last;
   logic          sel_user;

   assign state_dbg = state;

   msg_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .TW      (TW)
   ) u_pick (
      .req   (s_tvalid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign next_ptr = (grant == TW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
   assign acc      = |(s_tvalid & s_tready);

   // Route the granted source's sideband and payload.
   always_comb begin
      sel_data = '0;
      sel_keep = '0;
      sel_last = 1'b0;
      sel_user = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == TW'(i)) begin
            sel_data = s_tdata[i*DW +: DW];
            sel_keep = s_tkeep[i*KW +: KW];
            sel_last = s_tlast[i];
            sel_user = s_tuser[i];
         end
      end
   end

   // Only the granted source sees ready; draining ignores the output stage.
   always_comb begin
      s_tready = '0;
      case (state)
         PASS:    s_tready[grant] = !m_tvalid || m_tready;
         DRAIN:   s_tready[grant] = 1'b1;
         default: s_tready = '0;
      endcase
   end

   // Next-state, grant, pointer and beat counting.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr_ptr;
      cnt_nxt   = beat_cnt;
      load      = 1'b0;
      force_end = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_nxt = pick_idx;
               state_nxt = PASS;
            end
         end
         PASS: begin
            if (acc) begin
               load = 1'b1;
               if (sel_last) begin
                  cnt_nxt   = '0;
                  rr_nxt    = next_ptr;
                  state_nxt = IDLE;
               end else if (beat_cnt == CW'(MB - 1)) begin
                  cnt_nxt   = '0;
                  force_end = 1'b1;
                  state_nxt = DRAIN;
               end else begin
                  cnt_nxt = beat_cnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (acc && sel_last) begin
               rr_nxt    = next_ptr;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         rr_ptr   <= rr_nxt;
         beat_cnt <= cnt_nxt;
      end
   end

   // One-deep output stage; a truncated beat is marked last and errored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_tvalid     <= 1'b0;
         m_tlast      <= 1'b0;
         m_tuser      <= 1'b0;
         m_tkeep      <= '0;
         m_tdata      <= '0;
         m_tid        <= '0;
         pkt_overflow <= 1'b0;
      end else begin
         pkt_overflow <= force_end;
         if (load) begin
            m_tvalid <= 1'b1;
            m_tlast  <= sel_last | force_end;
            m_tuser  <= sel_user | force_end;
            m_tkeep  <= sel_keep;
            m_tdata  <= sel_data;
            m_tid    <= grant;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed bench for msg_stream_arbiter with a decoupled output scoreboard.
module tb_msg_stream_arbiter;

  localparam int N   = 4;
  localparam int KW  = 8;
  localparam int DW  = 64;
  localparam int TW  = 2;
  localparam int MB  = 4;
  localparam int W   = TW + 2 + KW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tuser;
  logic [N*KW-1:0] s_tkeep;
  logic [N*DW-1:0] s_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic            m_tuser;
  logic [KW-1:0]   m_tkeep;
  logic [DW-1:0]   m_tdata;
  logic [TW-1:0]   m_tid;
  logic            pkt_overflow;
  logic [1:0]      state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int pkt_seq = 0;
  bit bp_mode = 0;
  bit chk_fwd = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // downstream ready: held high, or toggled every cycle under back-pressure
  always @(posedge clk) begin
    #1;
    m_tready = bp_mode ? ~m_tready : 1'b1;
  end

  msg_stream_arbiter #(
    .NUM_SRC       (N),
    .DATA_BYTES    (8),
    .TKEEP_WIDTH   (KW),
    .MAX_MSG_BYTES (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .s_tuser      (s_tuser),
    .s_tkeep      (s_tkeep),
    .s_tdata      (s_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .m_tkeep      (m_tkeep),
    .m_tdata      (m_tdata),
    .m_tid        (m_tid),
    .pkt_overflow (pkt_overflow),
    .state_dbg    (state_dbg)
  );

  function automatic logic [DW-1:0] mk_md(input int s, input int k);
    return 64'hA5A5_0000_0000_0000 | (64'(s) << 16) | 64'(k);
  endfunction

  task automatic push_exp(input int tid, input logic last, input logic user,
                          input logic [KW-1:0] keep, input logic [DW-1:0] data);
    exp_q.push_back({TW'(tid), last, user, keep, data});
  endtask

  // monitor / scoreboard
  logic [W-1:0] cur_beat, prev_beat, exp_beat;
  bit prev_stall = 0;
  assign cur_beat = {m_tid, m_tlast, m_tuser, m_tkeep, m_tdata};

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (pkt_overflow) ovf_cnt++;
      if (prev_stall && m_tvalid) begin
        checks++;
        if (cur_beat !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold got %h exp %h", cur_beat, prev_beat);
        end
      end
      if (bp_mode && m_tvalid && !m_tready) begin
        checks++;
        if (s_tready !== '0) begin
          errors++;
          $display("FAIL bp_ready got %b exp 0000", s_tready);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %h exp none", cur_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          if (cur_beat !== exp_beat) begin
            errors++;
            $display("FAIL beat got %h exp %h", cur_beat, exp_beat);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur_beat;
    end
  end

  // driver: one packet of n beats from src; pushes its expected output
  task automatic send_pkt(input int src, input int n, input logic [7:0] user_mask,
                          input bit chk_lat);
    int waits;
    logic acc, lst, usr, trunc;
    logic [DW-1:0] d;
    logic [KW-1:0] kp;
    trunc = (n > MB);
    for (int b = 1; b <= n; b++) begin
      d   = {8'hD0, 8'(src), 8'(b), 8'(pkt_seq), 32'h1234_5678 ^ (32'(b) * 32'd17)};
      kp  = (b == n) ? 8'h0F : 8'hFF;
      lst = (b == n);
      usr = user_mask[3'(b - 1)];
      s_tvalid[src] = 1'b1;
      s_tlast[src]  = lst;
      s_tuser[src]  = usr;
      s_tkeep[src*KW +: KW] = kp;
      s_tdata[src*DW +: DW] = d;
      if (b <= MB) push_exp(src, lst || (b == MB && trunc), usr || (b == MB && trunc), kp, d);
      waits = 0;
      acc = 1'b0;
      while (!acc && waits < 200) begin
        @(negedge clk);
        if (chk_fwd) begin
          checks++;
          if (m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL fwd_latency got %b exp 1", m_tvalid);
          end
          chk_fwd = 0;
        end
        acc = s_tvalid[src] && s_tready[src];
        @(posedge clk);
        #1;
        waits++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got src %0d beat %0d exp accepted", src, b);
      end
      if (b == 1 && chk_lat) begin
        checks++;
        if (waits != 2) begin
          errors++;
          $display("FAIL sready_latency got %0d exp 2", waits);
        end
        chk_fwd = 1;
      end
    end
    s_tvalid[src] = 1'b0;
    s_tlast[src]  = 1'b0;
    s_tuser[src]  = 1'b0;
    pkt_seq++;
  endtask

  // driver: sources in mask hold 1-beat packets until npkts are accepted
  task automatic multi_send(input logic [N-1:0] mask, input int npkts);
    int k[N];
    int total, waits, last_cyc;
    logic [N-1:0] acc_v;
    total = 0;
    waits = 0;
    last_cyc = -1;
    for (int s = 0; s < N; s++) begin
      k[s] = 0;
      if (mask[TW'(s)]) begin
        s_tvalid[s] = 1'b1;
        s_tlast[s]  = 1'b1;
        s_tuser[s]  = 1'b0;
        s_tkeep[s*KW +: KW] = 8'hFF;
        s_tdata[s*DW +: DW] = mk_md(s, 0);
      end
    end
    while (total < npkts && waits < 400) begin
      @(negedge clk);
      acc_v = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      waits++;
      for (int s = 0; s < N; s++) begin
        if (acc_v[TW'(s)]) begin
          if (last_cyc >= 0) begin
            checks++;
            if (cyc - last_cyc != 2) begin
              errors++;
              $display("FAIL pkt_gap got %0d exp 2", cyc - last_cyc);
            end
          end
          last_cyc = cyc;
          total++;
          k[s]++;
          s_tdata[s*DW +: DW] = mk_md(s, k[s]);
        end
      end
      if (total >= npkts) s_tvalid = s_tvalid & ~mask;
    end
    if (total < npkts) begin
      checks++;
      errors++;
      $display("FAIL multi_timeout got %0d exp %0d", total, npkts);
    end
    s_tvalid = s_tvalid & ~mask;
    s_tlast  = s_tlast & ~mask;
  endtask

  task automatic wait_drain(input string name);
    int waits;
    waits = 0;
    while (exp_q.size() != 0 && waits < 100) begin
      @(posedge clk);
      #1;
      waits++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got %0d left exp 0", name, exp_q.size());
    end
  endtask

  task automatic check_zero(input string name);
    logic [W+N+1:0] outs;
    outs = {m_tvalid, pkt_overflow, m_tid, m_tlast, m_tuser, m_tkeep, m_tdata, s_tready};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s got %h exp 0", name, outs);
    end
  endtask

  // stimulus
  initial begin
    int ovf0, waits;
    logic acc;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    s_tkeep  = '0;
    s_tdata  = '0;

    #3;
    check_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // round robin from reset: 0,1,2,3,0
    push_exp(0, 1'b1, 1'b0, 8'hFF, mk_md(0, 0));
    push_exp(1, 1'b1, 1'b0, 8'hFF, mk_md(1, 0));
    push_exp(2, 1'b1, 1'b0, 8'hFF, mk_md(2, 0));
    push_exp(3, 1'b1, 1'b0, 8'hFF, mk_md(3, 0));
    push_exp(0, 1'b1, 1'b0, 8'hFF, mk_md(0, 1));
    multi_send(4'b1111, 5);
    wait_drain("rr");

    // single source 2, 3 beats
    send_pkt(2, 3, 8'h00, 1'b1);
    wait_drain("single");

    // back-pressure on source 1
    bp_mode = 1;
    send_pkt(1, 4, 8'h00, 1'b0);
    wait_drain("bp");
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // overflow: source 3, 6 beats
    ovf0 = ovf_cnt;
    send_pkt(3, 6, 8'h00, 1'b0);
    wait_drain("ovf");
    checks++;
    if (ovf_cnt - ovf0 != 1) begin
      errors++;
      $display("FAIL ovf_pulses got %0d exp 1", ovf_cnt - ovf0);
    end
    // pointer moved past 3: source 0 wins over 3
    push_exp(0, 1'b1, 1'b0, 8'hFF, mk_md(0, 0));
    push_exp(3, 1'b1, 1'b0, 8'hFF, mk_md(3, 0));
    multi_send(4'b1001, 2);
    wait_drain("after_ovf");

    // error passthrough on source 0
    ovf0 = ovf_cnt;
    send_pkt(0, 2, 8'b0000_0011, 1'b0);
    wait_drain("err");
    checks++;
    if (ovf_cnt != ovf0) begin
      errors++;
      $display("FAIL err_no_ovf got %0d exp 0", ovf_cnt - ovf0);
    end

    // reset during beat 2 of a source 1 packet
    s_tvalid[1] = 1'b1;
    s_tlast[1]  = 1'b0;
    s_tkeep[KW +: KW] = 8'hFF;
    s_tdata[DW +: DW] = 64'h1111_1111_1111_1111;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = s_tvalid[1] && s_tready[1];
      @(posedge clk);
      #1;
      waits++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL rst_beat1 got timeout exp accepted");
    end
    s_tdata[DW +: DW] = 64'h2222_2222_2222_2222;
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_zero("midpkt_reset_outputs");
    s_tvalid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_exp(0, 1'b1, 1'b0, 8'hFF, mk_md(0, 0));
    push_exp(1, 1'b1, 1'b0, 8'hFF, mk_md(1, 0));
    multi_send(4'b0011, 2);
    wait_drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
